// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - EX request, data-memory and writeback signals of the MEM-stage load/store unit
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  // EX-stage request
  logic              i_valid;
  logic              i_is_load;
  logic              i_is_store;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [DATA_W-1:0] i_eff_addr;
  logic [DATA_W-1:0] i_store_data;
  logic [REG_W-1:0]  i_rd;
  logic              o_ready;
  logic              o_stall;

  // Data memory
  logic              o_mem_req;
  logic              o_mem_we;
  logic [DATA_W-1:0] o_mem_addr;
  logic [3:0]        o_mem_be;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;

  // Writeback and exceptions
  logic              o_wb_valid;
  logic [REG_W-1:0]  o_wb_rd;
  logic [DATA_W-1:0] o_wb_data;
  logic [1:0]        o_exception;

  modport slave (
    input  i_valid, i_is_load, i_is_store, i_size, i_unsigned, i_eff_addr, i_store_data, i_rd,
    input  i_mem_ack, i_mem_rdata,
    output o_ready, o_stall,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    output o_wb_valid, o_wb_rd, o_wb_data, o_exception
  );

  modport master (
    output i_valid, i_is_load, i_is_store, i_size, i_unsigned, i_eff_addr, i_store_data, i_rd,
    output i_mem_ack, i_mem_rdata,
    input  o_ready, o_stall,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    input  o_wb_valid, o_wb_rd, o_wb_data, o_exception
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: alignment checks, byte-lane memory handshake, load extension
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mem_access_unit_if.slave  bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_EXC  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] EXC_NONE      = 2'b00;
  localparam logic [1:0] EXC_LOAD_MIS  = 2'b01;
  localparam logic [1:0] EXC_STORE_MIS = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL   = 2'b11;

  logic [1:0]        state;
  logic [1:0]        r_lane;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_is_load;
  logic [REG_W-1:0]  r_rd;

  logic              accept;
  logic [1:0]        exc_code;
  logic [3:0]        be_next;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] lane_word;
  logic [DATA_W-1:0] load_ext;

  assign accept      = (state == ST_IDLE) && bus.i_valid && (bus.i_is_load || bus.i_is_store);
  assign bus.o_ready = (state == ST_IDLE);
  assign bus.o_stall = (state != ST_IDLE);

  // Illegal takes priority over misalignment.
  always_comb begin
    exc_code = EXC_NONE;
    if ((bus.i_is_load && bus.i_is_store) || (bus.i_size == SZ_RSVD)) begin
      exc_code = EXC_ILLEGAL;
    end else if (((bus.i_size == SZ_HALF) && bus.i_eff_addr[0]) ||
                 ((bus.i_size == SZ_WORD) && (bus.i_eff_addr[1:0] != 2'b00))) begin
      exc_code = bus.i_is_load ? EXC_LOAD_MIS : EXC_STORE_MIS;
    end
  end

  always_comb begin
    be_next    = 4'b0000;
    wdata_next = '0;
    case (bus.i_size)
      SZ_BYTE: begin
        be_next    = 4'b0001 << bus.i_eff_addr[1:0];
        wdata_next = {4{bus.i_store_data[7:0]}};
      end
      SZ_HALF: begin
        be_next    = bus.i_eff_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{bus.i_store_data[15:0]}};
      end
      SZ_WORD: begin
        be_next    = 4'b1111;
        wdata_next = bus.i_store_data;
      end
      default: begin
        be_next    = 4'b0000;
        wdata_next = '0;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend from the access size.
  always_comb begin
    lane_word = bus.i_mem_rdata >> {r_lane, 3'b000};
    load_ext  = lane_word;
    case (r_size)
      SZ_BYTE: load_ext = {{(DATA_W-8){~r_unsigned & lane_word[7]}}, lane_word[7:0]};
      SZ_HALF: load_ext = {{(DATA_W-16){~r_unsigned & lane_word[15]}}, lane_word[15:0]};
      default: load_ext = bus.i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= ST_IDLE;
      r_lane          <= 2'b00;
      r_size          <= SZ_BYTE;
      r_unsigned      <= 1'b0;
      r_is_load       <= 1'b0;
      r_rd            <= '0;
      bus.o_mem_req   <= 1'b0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_be    <= 4'b0000;
      bus.o_mem_wdata <= '0;
      bus.o_wb_valid  <= 1'b0;
      bus.o_wb_rd     <= '0;
      bus.o_wb_data   <= '0;
      bus.o_exception <= EXC_NONE;
    end else begin
      bus.o_wb_valid  <= 1'b0;
      bus.o_exception <= EXC_NONE;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            r_lane     <= bus.i_eff_addr[1:0];
            r_size     <= bus.i_size;
            r_unsigned <= bus.i_unsigned;
            r_is_load  <= bus.i_is_load;
            r_rd       <= bus.i_rd;
            if (exc_code != EXC_NONE) begin
              bus.o_exception <= exc_code;
              state           <= ST_EXC;
            end else begin
              bus.o_mem_req   <= 1'b1;
              bus.o_mem_we    <= bus.i_is_store;
              bus.o_mem_addr  <= {bus.i_eff_addr[DATA_W-1:2], 2'b00};
              bus.o_mem_be    <= be_next;
              bus.o_mem_wdata <= wdata_next;
              state           <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus.i_mem_ack) begin
            bus.o_mem_req <= 1'b0;
            bus.o_mem_we  <= 1'b0;
            if (r_is_load) begin
              bus.o_wb_valid <= 1'b1;
              bus.o_wb_rd    <= r_rd;
              bus.o_wb_data  <= load_ext;
              state          <= ST_RESP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_EXC:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit of the MEM stage. It consumes the effective address produced by the execute-stage address generator, checks alignment, and drives a byte-lane handshake to data memory. It returns sign- or zero-extended load data to writeback and stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- `DATA_W`, default 32: data and address width. The byte-lane logic is fixed at 4 lanes, so only 32 is legal.
- `REG_W`, default 5: destination register index width.

Ports:
- `i_clk`, input, 1: clock; everything is on the rising edge.
- `i_reset`, input, 1: asynchronous, active-high reset.
- `i_valid`, input, 1: request from EX is present.
- `i_is_load`, input, 1: request is a load.
- `i_is_store`, input, 1: request is a store.
- `i_size`, input, 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `i_unsigned`, input, 1: load zero-extends when 1 and sign-extends when 0.
- `i_eff_addr`, input, 32: effective byte address.
- `i_store_data`, input, 32: store source; the relevant data is in the low bits.
- `i_rd`, input, `REG_W`: load destination register.
- `o_ready`, output, 1: unit can accept a request this cycle.
- `o_stall`, output, 1: pipeline stall; equals `!o_ready`.
- `o_mem_req`, output, 1: memory request, held until acknowledged.
- `o_mem_we`, output, 1: 1 = write.
- `o_mem_addr`, output, 32: word address, i.e. `{eff_addr[31:2], 2'b00}`.
- `o_mem_be`, output, 4: byte enables, little-endian (lane 0 = bits 7:0).
- `o_mem_wdata`, output, 32: write data replicated across lanes.
- `i_mem_ack`, input, 1: memory completed the access this cycle; `i_mem_rdata` is valid with it.
- `i_mem_rdata`, input, 32: read word.
- `o_wb_valid`, output, 1: one-cycle pulse; load result is valid.
- `o_wb_rd`, output, `REG_W`: destination register for the load result.
- `o_wb_data`, output, 32: extended load result.
- `o_exception`, output, 2: one-cycle pulse. 00 = none, 01 = load misaligned, 10 = store misaligned, 11 = illegal request.

## Operation
**States:** IDLE, REQ, RESP, EXC.

**Accept.** A request is accepted when the unit is in IDLE and `i_valid && (i_is_load || i_is_store)`. On acceptance the address, size, unsigned flag, rd and store data are registered. A request with `i_valid` high but neither load nor store set is ignored, and the unit stays in IDLE.

**Checks on the accepted request**, in priority order:
1. Illegal request (load and store both set, or size 11): go to EXC with code 11.
2. Misaligned access (half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 00): go to EXC with code 01 for a load or 10 for a store.
3. Otherwise go to REQ.

**EXC.** `o_exception` carries the code for exactly one cycle, no memory request is issued, and the next state is IDLE.

**REQ.**
- `o_mem_req` = 1. `o_mem_addr`, `o_mem_we`, `o_mem_be` and `o_mem_wdata` stay stable until ack.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: 0011 if `addr[1]` = 0, 1100 if `addr[1]` = 1
  - word: 1111
- Write data: byte = `{4{sd[7:0]}}`, half = `{2{sd[15:0]}}`, word = `sd`.
- On `i_mem_ack`:
  - store: go to IDLE.
  - load: capture the selected lane, extend it into `o_wb_data`, and go to RESP.

**Load extraction.**
- byte: `rdata[8*addr[1:0] +: 8]`
- half: `rdata[16*addr[1] +: 16]`
- The value is extended to 32 bits per the registered `i_unsigned`.

**RESP.** `o_wb_valid` = 1 for one cycle with `o_wb_rd` and `o_wb_data`, then go to IDLE.

**Readiness.** `o_ready` is 1 only in IDLE. There are no back-to-back accepts from any other state.

**Reset.** Asserting `i_reset`, including mid-access, forces IDLE immediately and zeroes every output except `o_ready`, which reads 1. An outstanding memory request is abandoned, and any later ack is ignored.

## Timing
**Reset values:** `o_ready` = 1, `o_stall` = 0. `o_mem_req`, `o_mem_we`, `o_wb_valid` = 0. `o_mem_addr`, `o_mem_be`, `o_mem_wdata`, `o_wb_data`, `o_wb_rd`, `o_exception` = 0.

**Cycle numbering.** The request is accepted at the edge ending cycle T, so the unit leaves IDLE in cycle T+1.

**Memory request timing.**
- `o_mem_req` is high from cycle T+1 until and including the ack cycle.
- An ack in the same cycle as `o_mem_req` first rises (cycle T+1) is legal.
- Wait states are unbounded. There is no timeout.

**Latencies with a zero-wait ack (ack at T+1):**
- Load: `o_wb_valid` in cycle T+2; the next accept is possible in T+3.
- Store: IDLE in cycle T+2, which is also when the next accept is possible.
- Exception: `o_exception` pulses in cycle T+1; IDLE in T+2.

**Ack rules.** An ack while in IDLE, RESP or EXC is ignored. The memory must not ack with `o_mem_req` low.

**Registered outputs.** All outputs are registered except `o_ready` and `o_stall`, which are decoded from state.

## Test plan
1. Load byte, signed: addr 0x1003, memory returns 0x80FF_1234 with ack one cycle after req -> `o_mem_be` = 1000, `o_mem_addr` = 0x1000, wb data 0xFFFF_FF80, `o_wb_valid` at T+2.
2. Store half: addr 0x2002, sd 0xDEAD_BEEF, ack after 3 wait cycles -> be = 1100, wdata = 0xBEEF_BEEF, req held 4 cycles, `o_stall` high throughout, no wb pulse.
3. Misaligned word load at addr 0x3001 -> `o_exception` = 01 for one cycle, `o_mem_req` never asserted, `o_ready` back to 1 at T+2. Repeat as a store -> code 10.
4. Illegal request: load and store both set, or size 11 -> code 11, no memory request.
5. Reset asserted in REQ with an ack pending -> `o_mem_req` drops immediately, the ack arriving after reset release is ignored, no wb pulse.
6. Back-to-back word stores with zero-wait ack -> each accepted every 2 cycles. Unsigned half load at addr 0x0 with rdata 0x1234_8001 -> wb data 0x0000_8001.
